// File: rtl/wm_pkg.sv
// Shared types and constants for the watermark embedder.
package wm_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wm_state_t;

    localparam logic WM_MODE_1B   = 1'b0;
    localparam logic WM_MODE_2B   = 1'b1;
    localparam int   WM_PIX_W_DEF = 8;

    function automatic logic [7:0] wm_rotl8(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction
endpackage

// File: rtl/wm_lsb_insert.sv
// Combinational LSB substitution: bit 0 always carries wm_data[0], bit 1 carries
// wm_data[1] only in 2-bit mode, upper bits pass through.
module wm_lsb_insert
    import wm_pkg::*;
#(
    parameter int PIX_W = WM_PIX_W_DEF
) (
    input  logic [PIX_W-1:0] pixel,
    input  logic [1:0]       wm_data,
    input  logic             mode,
    output logic [PIX_W-1:0] pixel_wm
);
    generate
        for (genvar gi = 0; gi < PIX_W; gi++) begin : g_bit
            if (gi == 0) begin : g_b0
                assign pixel_wm[gi] = wm_data[0];
            end else if (gi == 1) begin : g_b1
                assign pixel_wm[gi] = (mode == WM_MODE_2B) ? wm_data[1] : pixel[gi];
            end else begin : g_pass
                assign pixel_wm[gi] = pixel[gi];
            end
        end
    endgenerate
endmodule

// File: rtl/wm_embed.sv
// Watermark embedder: frame FSM, pixel counter and one-deep output register.
// Optional WM_CHECKSUM_EN adds a rotating XOR checksum of embedded bits (wm_sum).
module wm_embed
    import wm_pkg::*;
#(
    parameter int PIX_W     = WM_PIX_W_DEF,
    parameter int FRAME_PIX = 4096,
    parameter int CNT_W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             wm_select,
    input  logic [1:0]       wm_data,
    output logic             wm_step,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_pixel,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_pixel,
    output logic             m_last,
    output logic             busy,
    output logic             done
`ifdef WM_CHECKSUM_EN
    ,
    output logic [7:0]       wm_sum
`endif
);
    wm_state_t        state_reg, state_next;
    logic [CNT_W-1:0] count_reg;
    logic             mode_reg;
    logic             m_valid_reg;
    logic             m_last_reg;
    logic [PIX_W-1:0] m_pixel_reg;
    logic [PIX_W-1:0] pixel_wm;
    logic             accept;
    logic             last_accept;
    logic             start_ok;

    wm_lsb_insert #(.PIX_W(PIX_W)) u_insert (
        .pixel    (s_pixel),
        .wm_data  (wm_data),
        .mode     (mode_reg),
        .pixel_wm (pixel_wm)
    );

    // Output register may reload in the same cycle it is drained.
    assign s_ready     = (state_reg == RUN) && (!m_valid_reg || m_ready);
    assign accept      = s_valid && s_ready;
    assign last_accept = accept && (count_reg == CNT_W'(FRAME_PIX - 1));
    assign start_ok    = (state_reg == IDLE) && start;
    assign wm_step     = accept;
    assign busy        = (state_reg == RUN) || (state_reg == DRAIN);
    assign done        = (state_reg == DONE);
    assign m_valid     = m_valid_reg;
    assign m_last      = m_last_reg;
    assign m_pixel     = m_pixel_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_accept) state_next = DRAIN;
            DRAIN:   if (m_valid_reg && m_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            mode_reg    <= WM_MODE_1B;
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
            m_pixel_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                count_reg <= '0;
                mode_reg  <= wm_select;
            end else if (accept && !last_accept) begin
                count_reg <= count_reg + 1'b1;
            end
            if (accept) begin
                m_valid_reg <= 1'b1;
                m_pixel_reg <= pixel_wm;
                m_last_reg  <= last_accept;
            end else if (m_ready) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

`ifdef WM_CHECKSUM_EN
    logic [7:0] wm_sum_reg;
    logic [1:0] emb_bits;

    assign emb_bits = (mode_reg == WM_MODE_2B) ? wm_data : {1'b0, wm_data[0]};
    assign wm_sum   = wm_sum_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wm_sum_reg <= '0;
        end else if (start_ok) begin
            wm_sum_reg <= '0;
        end else if (accept) begin
            wm_sum_reg <= wm_rotl8(wm_sum_reg) ^ {6'b0, emb_bits};
        end
    end
`endif
endmodule

// File: tb/tb_wm_embed.sv
// Scoreboard bench for wm_embed with a 4-pixel frame.
module tb_wm_embed;
    import wm_pkg::*;

    localparam int PIX_W     = 8;
    localparam int FRAME_PIX = 4;
    localparam int CNT_W     = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             wm_select = 1'b0;
    logic [1:0]       wm_data = 2'b00;
    logic             wm_step;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [PIX_W-1:0] s_pixel = '0;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [PIX_W-1:0] m_pixel;
    logic             m_last;
    logic             busy;
    logic             done;
`ifdef WM_CHECKSUM_EN
    logic [7:0]       wm_sum;
    logic [7:0]       sum_model = 8'h00;
`endif

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic             last;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    int               checks = 0;
    int               errors = 0;
    int               step_cnt = 0;
    int               done_cnt = 0;
    int               out_cnt = 0;
    int               in_idx = 0;
    int               cyc = 0;
    logic             cur_mode = 1'b0;
    logic [PIX_W-1:0] last_out = '0;

    wm_embed #(.PIX_W(PIX_W), .FRAME_PIX(FRAME_PIX), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .wm_select (wm_select),
        .wm_data   (wm_data),
        .wm_step   (wm_step),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_pixel   (s_pixel),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_pixel   (m_pixel),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
`ifdef WM_CHECKSUM_EN
        ,
        .wm_sum    (wm_sum)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PIX_W-1:0] model_embed(input logic [PIX_W-1:0] p,
                                                     input logic [1:0] w, input logic m);
        return m ? {p[PIX_W-1:2], w} : {p[PIX_W-1:1], w[0]};
    endfunction

    // Monitor on the falling edge: push expected on accept, pop on output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (wm_step) step_cnt++;
            if (done) begin
                done_cnt++;
`ifdef WM_CHECKSUM_EN
                checks++;
                if (wm_sum !== sum_model) begin
                    errors++;
                    $display("FAIL wm_sum got %h expected %h", wm_sum, sum_model);
                end
`endif
            end
            if (s_valid && s_ready) begin
                exp_q.push_back({model_embed(s_pixel, wm_data, cur_mode), in_idx == FRAME_PIX - 1});
`ifdef WM_CHECKSUM_EN
                sum_model = {sum_model[6:0], sum_model[7]} ^
                            {6'b0, (cur_mode ? wm_data : {1'b0, wm_data[0]})};
`endif
                in_idx++;
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected got pix=%h last=%b with empty scoreboard",
                             m_pixel, m_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (m_pixel !== mon_e.pix || m_last !== mon_e.last) begin
                        errors++;
                        $display("FAIL out_pixel got pix=%h last=%b expected pix=%h last=%b",
                                 m_pixel, m_last, mon_e.pix, mon_e.last);
                    end
                    last_out = m_pixel;
                    out_cnt++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic start_frame(input logic mode);
        @(posedge clk);
        #1 start = 1'b1; wm_select = mode; cur_mode = mode; in_idx = 0;
`ifdef WM_CHECKSUM_EN
        sum_model = 8'h00;
`endif
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_pixel(input logic [PIX_W-1:0] p, input logic [1:0] w);
        bit ok = 1'b0;
        s_valid = 1'b1; s_pixel = p; wm_data = w;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout pixel %h not accepted within 50 cycles", p);
        end
    endtask

    task automatic wait_done(input string tag, input int out0, input int step0);
        int d0 = done_cnt;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_cnt != d0) break;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt != d0 + 1) begin
            errors++; $display("FAIL %s done_pulses got %0d expected 1", tag, done_cnt - d0);
        end
        checks++;
        if (out_cnt - out0 != FRAME_PIX) begin
            errors++; $display("FAIL %s outputs got %0d expected %0d", tag, out_cnt - out0, FRAME_PIX);
        end
        checks++;
        if (step_cnt - step0 != FRAME_PIX) begin
            errors++; $display("FAIL %s wm_step got %0d expected %0d", tag, step_cnt - step0, FRAME_PIX);
        end
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL %s idle busy=%b pending=%0d expected 0/0", tag, busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({m_valid, m_last, busy, done, wm_step, s_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got v=%b l=%b b=%b d=%b st=%b r=%b expected all 0",
                     m_valid, m_last, busy, done, wm_step, s_ready);
        end
        checks++;
        if (m_pixel !== '0) begin
            errors++; $display("FAIL reset_pixel got %h expected 00", m_pixel);
        end
    endtask

    task automatic test_mode0();
        int o0 = out_cnt, s0 = step_cnt;
        start_frame(WM_MODE_1B);
        send_pixel(8'hFF, 2'b00);
        send_pixel(8'hFF, 2'b00);
        send_pixel(8'h00, 2'b01);
        send_pixel(8'h00, 2'b01);
        wait_done("mode0", o0, s0);
        checks++;
        if (last_out !== 8'h01) begin
            errors++; $display("FAIL mode0_last_pixel got %h expected 01", last_out);
        end
    endtask

    task automatic test_mode1();
        int o0 = out_cnt, s0 = step_cnt;
        start_frame(WM_MODE_2B);
        send_pixel(8'h3C, 2'b10);
        send_pixel(8'h00, 2'b01);
        send_pixel(8'hFF, 2'b00);
        send_pixel(8'hA4, 2'b11);
        wait_done("mode1", o0, s0);
        checks++;
        if (last_out !== 8'hA7) begin
            errors++; $display("FAIL mode1_pixel got %h expected A7", last_out);
        end
    endtask

    task automatic test_stall();
        int o0 = out_cnt, s0 = step_cnt;
        start_frame(WM_MODE_1B);
        send_pixel(8'h5A, 2'b01);
        send_pixel(8'h5B, 2'b00);
        m_ready = 1'b0;
        s_valid = 1'b1; s_pixel = 8'hC3; wm_data = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0 || wm_step !== 1'b0 || m_valid !== 1'b1 || m_pixel !== 8'h5A) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got r=%b st=%b v=%b pix=%h expected 0/0/1/5A",
                         i, s_ready, wm_step, m_valid, m_pixel);
            end
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        send_pixel(8'hC3, 2'b01);
        send_pixel(8'hC4, 2'b00);
        wait_done("stall", o0, s0);
    endtask

    task automatic test_start_ignored();
        int o0 = out_cnt, s0 = step_cnt;
        start_frame(WM_MODE_2B);
        send_pixel(8'h10, 2'b11);
        send_pixel(8'h20, 2'b10);
        start = 1'b1; wm_select = WM_MODE_1B;
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL start_in_run busy got %b expected 1", busy);
        end
        send_pixel(8'h30, 2'b01);
        send_pixel(8'h40, 2'b10);
        wait_done("start_ignored", o0, s0);
    endtask

    task automatic test_rst_mid();
        int d0, s0, o0;
        start_frame(WM_MODE_1B);
        send_pixel(8'h11, 2'b00);
        send_pixel(8'h22, 2'b01);
        m_ready = 1'b0; rst = 1'b1;
        d0 = done_cnt; s0 = step_cnt;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_valid, busy, done, s_ready} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid got v=%b b=%b d=%b r=%b expected all 0", m_valid, busy, done, s_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != d0 || step_cnt != s0) begin
            errors++;
            $display("FAIL rst_mid_side got done=%0d steps=%0d expected 0/0", done_cnt - d0, step_cnt - s0);
        end
        exp_q.delete();
        m_ready = 1'b1;
        o0 = out_cnt; s0 = step_cnt;
        start_frame(WM_MODE_1B);
        send_pixel(8'hFF, 2'b00);
        send_pixel(8'hFF, 2'b00);
        send_pixel(8'h00, 2'b01);
        send_pixel(8'h00, 2'b01);
        wait_done("rst_recover", o0, s0);
    endtask

    task automatic test_back_to_back();
        int o0 = out_cnt, s0 = step_cnt, c0;
        start_frame(WM_MODE_2B);
        c0 = cyc;
        for (int i = 0; i < FRAME_PIX; i++) send_pixel(8'(8'h80 + i), 2'(i));
        checks++;
        if (cyc - c0 != FRAME_PIX) begin
            errors++; $display("FAIL back_to_back cycles got %0d expected %0d", cyc - c0, FRAME_PIX);
        end
        wait_done("back_to_back", o0, s0);
    endtask

`ifdef WM_CHECKSUM_EN
    task automatic test_checksum();
        int o0 = out_cnt, s0 = step_cnt;
        start_frame(WM_MODE_2B);
        send_pixel(8'h00, 2'b01);
        send_pixel(8'h00, 2'b10);
        send_pixel(8'h00, 2'b11);
        send_pixel(8'h00, 2'b00);
        wait_done("checksum", o0, s0);
        checks++;
        if (wm_sum !== sum_model) begin
            errors++; $display("FAIL wm_sum_hold got %h expected %h", wm_sum, sum_model);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_stall();
        test_start_ignored();
        test_rst_mid();
        test_back_to_back();
`ifdef WM_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
